// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of dmem_arbiter.
// Port A is the MEM stage, port B is the loader/debug master. The slave
// modport is the arbiter's view. The master modport is the requesters' view.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic                  pipe_stall;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  pipe_stall
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output pipe_stall
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory of core_lapido.
// A (MEM stage) has fixed priority over B (loader/debug). One access is
// issued per cycle. Synchronous read data is steered back to its owner one
// cycle later. pipe_stall flags a MEM-stage request that was not granted.
// Optional feature: define DMEM_ARB_STARVE_EN to force B through after it
// has been denied STARVE_LIMIT consecutive cycles.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be within 1..255");
  end

  // Owner of the read data that the memory returns in the current cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2
  } rd_state_e;

  rd_state_e state;
  rd_state_e state_next;
  logic      a_gnt;
  logic      b_gnt;
  logic      force_b;

  // Read-owner register; asynchronous reset drops any pending return.
  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

`ifdef DMEM_ARB_STARVE_EN
  logic [7:0] starve_cnt;

  // Count consecutive cycles in which B waits. Any B grant (forced or not)
  // or a dropped B request restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!bus.b_req || b_gnt) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  assign force_b = (starve_cnt == STARVE_LIMIT[7:0]);
`else
  assign force_b = 1'b0;
`endif

  // Grant decision. Reset gates both grants so nothing reaches memory during reset.
  // NOTE: every signal written in an always_comb gets a value on every
  // path (defaults first where branches exist) so no latch is inferred.
  always_comb begin
    a_gnt          = rst & bus.a_req & ~force_b;
    b_gnt          = rst & bus.b_req & (~bus.a_req | force_b);
    bus.a_gnt      = a_gnt;
    bus.b_gnt      = b_gnt;
    bus.pipe_stall = rst & bus.a_req & ~a_gnt;
  end

  // Memory mux: the granted port drives the memory, and the bus is idle (all zero) otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (a_gnt) begin
      mem_addr  = bus.a_addr;
      mem_wdata = bus.a_wdata;
      mem_we    = bus.a_we;
    end else if (b_gnt) begin
      mem_addr  = bus.b_addr;
      mem_wdata = bus.b_wdata;
      mem_we    = bus.b_we;
    end
  end

  // Next read owner: a granted load owns the next cycle's read data.
  always_comb begin
    state_next = IDLE;
    if (a_gnt && !bus.a_we) begin
      state_next = RD_A;
    end else if (b_gnt && !bus.b_we) begin
      state_next = RD_B;
    end
  end

  // Read return: only the owner sees the memory data. Other ports see zero.
  always_comb begin
    bus.a_rvalid = (state == RD_A);
    bus.b_rvalid = (state == RD_B);
    bus.a_rdata  = bus.a_rvalid ? mem_rdata : '0;
    bus.b_rdata  = bus.b_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. A small data_mem stand-in provides
// synchronous reads. A behavioural model (owner choice, pending-response
// record, reference memory) is checked against the DUT on every negedge.
// Directed tests pin the model with literal values. A randomized phase follows.
module tb_dmem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
  localparam int NONE  = 0;
  localparam int PA    = 1;
  localparam int PB    = 2;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      1:       return 32'hA5A5_0004;
      2:       return 32'h5A5A_0008;
      8:       return 32'h1234_5678;
      default: return 32'h0;
    endcase
  endfunction

  // data_mem stand-in: 64 words, synchronous read, write on write_en
  logic [31:0] dmem [64];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) dmem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      mem_rdata <= dmem[mem_addr[7:2]];
      if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem [64];
  bit          ref_ready = 1'b0;
  int          pend_owner;
  logic [31:0] pend_data;
  int          b_wait;
  int          owner;
  logic [31:0] e_addr, e_wdata;
  logic        e_we;

  always @(negedge clk) begin
    if (!ref_ready) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      ref_ready  = 1'b1;
      pend_owner = NONE;
      b_wait     = 0;
    end
    // Who owns the memory this cycle
    if (!rst) owner = NONE;
    else if (STARVE_ON && bus.b_req && b_wait == LIMIT) owner = PB;
    else if (bus.a_req) owner = PA;
    else if (bus.b_req) owner = PB;
    else owner = NONE;

    e_addr = 32'h0; e_wdata = 32'h0; e_we = 1'b0;
    if (owner == PA) begin e_addr = bus.a_addr; e_wdata = bus.a_wdata; e_we = bus.a_we; end
    if (owner == PB) begin e_addr = bus.b_addr; e_wdata = bus.b_wdata; e_we = bus.b_we; end

    check("a_gnt", 64'(bus.a_gnt), 64'(owner == PA));
    check("b_gnt", 64'(bus.b_gnt), 64'(owner == PB));
    check("pipe_stall", 64'(bus.pipe_stall), 64'(rst && bus.a_req && owner != PA));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("a_rvalid", 64'(bus.a_rvalid), 64'(rst && pend_owner == PA));
    check("b_rvalid", 64'(bus.b_rvalid), 64'(rst && pend_owner == PB));
    check("a_rdata", 64'(bus.a_rdata), (rst && pend_owner == PA) ? 64'(pend_data) : 64'h0);
    check("b_rdata", 64'(bus.b_rdata), (rst && pend_owner == PB) ? 64'(pend_data) : 64'h0);

    // Advance the model to what the next cycle must show
    pend_owner = NONE;
    if (!rst) begin
      b_wait = 0;
    end else begin
      if (owner != NONE) begin
        if (e_we) ref_mem[e_addr[7:2]] = e_wdata;
        else begin
          pend_owner = owner;
          pend_data  = ref_mem[e_addr[7:2]];
        end
      end
      if (bus.b_req && owner != PB) b_wait++;
      else b_wait = 0;
    end
  end

  // ---------------- stimulus ----------------
  int   n_bgnt, bgnt_at;
  logic stall_at;
  bit   a_hold, b_hold, granted;

  initial begin
    rst = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'h10; bus.a_wdata = 32'hFFFF_FFFF;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 32'h0;  bus.b_wdata = 32'h0;

    // 1. Reset with a pending store request: nothing may reach memory
    for (int i = 0; i < 3; i++) begin
      mid();
      check("rst_mem_we", 64'(mem_we), 64'h0);
      check("rst_a_gnt", 64'(bus.a_gnt), 64'h0);
      check("rst_pipe_stall", 64'(bus.pipe_stall), 64'h0);
      check("rst_mem_addr", 64'(mem_addr), 64'h0);
      cyc();
    end
    check("rst_mem_unchanged", 64'(dmem[4]), 64'h0);

    // 2. A store then load at 0x10
    rst = 1'b1;
    bus.a_wdata = 32'hDEAD_BEEF;
    mid();
    check("st_a_gnt", 64'(bus.a_gnt), 64'h1);
    check("st_mem_we", 64'(mem_we), 64'h1);
    cyc();
    bus.a_we = 1'b0;
    mid();
    check("ld_a_gnt", 64'(bus.a_gnt), 64'h1);
    cyc();
    bus.a_req = 1'b0;
    mid();
    check("ld_a_rvalid", 64'(bus.a_rvalid), 64'h1);
    check("ld_a_rdata", 64'(bus.a_rdata), 64'hDEAD_BEEF);
    check("ld_b_rvalid", 64'(bus.b_rvalid), 64'h0);
    cyc();

    // 3. Contention: A store vs B load of 0x20
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'h30; bus.a_wdata = 32'h1111_1111;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'h20;
    mid();
    check("cont_a_gnt", 64'(bus.a_gnt), 64'h1);
    check("cont_b_gnt", 64'(bus.b_gnt), 64'h0);
    cyc();
    bus.a_req = 1'b0;
    mid();
    check("cont_b_gnt_late", 64'(bus.b_gnt), 64'h1);
    cyc();
    bus.b_req = 1'b0;
    mid();
    check("cont_b_rvalid", 64'(bus.b_rvalid), 64'h1);
    check("cont_b_rdata", 64'(bus.b_rdata), 64'h1234_5678);
    cyc();

    // 4. Back-to-back reads: A at 0x4, then B at 0x8
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h4;
    mid();
    cyc();
    bus.a_req = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'h8;
    mid();
    check("b2b_a_rvalid", 64'(bus.a_rvalid), 64'h1);
    check("b2b_a_rdata", 64'(bus.a_rdata), 64'hA5A5_0004);
    check("b2b_b_rvalid0", 64'(bus.b_rvalid), 64'h0);
    cyc();
    bus.b_req = 1'b0;
    mid();
    check("b2b_b_rvalid", 64'(bus.b_rvalid), 64'h1);
    check("b2b_b_rdata", 64'(bus.b_rdata), 64'h5A5A_0008);
    check("b2b_a_rvalid1", 64'(bus.a_rvalid), 64'h0);
    cyc();

    // 5. Starvation: A requests every cycle, B holds a store
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h4;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 32'h3C; bus.b_wdata = 32'hCAFE_F00D;
    n_bgnt = 0; bgnt_at = -1; stall_at = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mid();
      granted = bus.b_gnt;
      if (granted) begin
        n_bgnt++;
        bgnt_at  = i;
        stall_at = bus.pipe_stall;
      end
      cyc();
      if (granted) bus.b_req = 1'b0;
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
    check("starve_b_gnt_count", 64'(n_bgnt), 64'd1);
    check("starve_b_gnt_cycle", 64'(bgnt_at), 64'd4);
    check("starve_pipe_stall", 64'(stall_at), 64'h1);
`else
    check("starve_b_gnt_count", 64'(n_bgnt), 64'd0);
`endif

    // 6. Reset pulsed the cycle after a load grant
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h8;
    mid();
    check("rmr_a_gnt", 64'(bus.a_gnt), 64'h1);
    cyc();
    rst = 1'b0;
    bus.a_req = 1'b0;
    mid();
    check("rmr_a_rvalid", 64'(bus.a_rvalid), 64'h0);
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("rmr_post_a_rvalid", 64'(bus.a_rvalid), 64'h0);
      check("rmr_post_b_rvalid", 64'(bus.b_rvalid), 64'h0);
      cyc();
    end

    // 7. Randomized traffic with occasional reset pulses
    a_hold = 1'b0; b_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!rst) rst = 1'b1;
      else rst = ($urandom_range(0, 59) != 0);
      if (!a_hold) begin
        bus.a_req   = ($urandom_range(0, 2) != 0);
        bus.a_we    = 1'($urandom_range(0, 1));
        bus.a_addr  = 32'($urandom_range(0, 63)) << 2;
        bus.a_wdata = $urandom;
      end
      if (!b_hold) begin
        bus.b_req   = 1'($urandom_range(0, 1));
        bus.b_we    = 1'($urandom_range(0, 1));
        bus.b_addr  = 32'($urandom_range(0, 63)) << 2;
        bus.b_wdata = $urandom;
      end
      mid();
      a_hold = rst && bus.a_req && !bus.a_gnt;
      b_hold = rst && bus.b_req && !bus.b_gnt;
      cyc();
    end
    rst = 1'b1;
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    mid();
    cyc();

    for (int i = 0; i < 64; i++) check($sformatf("mem_word_%0d", i), 64'(dmem[i]), 64'(ref_mem[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer in front of the single-port data memory (`data_mem`) of the core_lapido pipeline. Port A is the MEM stage, which issues loads and stores from the EX/MEM register. Port B is the secondary master, the program/data loader or debug port. The block grants one access per cycle and routes the synchronous read data back to the owner one cycle later. It raises a pipeline stall whenever the MEM stage loses arbitration.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: address width of both requesters and of the memory.
- `DATA_WIDTH`, 32: data width.
- `STARVE_LIMIT`, 8: number of consecutive denied B cycles before B is forced through. Used only with `DMEM_ARB_STARVE_EN`. Legal range is 1..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `a_req`  in  1  MEM stage access request.
- `a_we`  in  1  1 = store, 0 = load.
- `a_addr`  in  ADDR_WIDTH  MEM stage address.
- `a_wdata`  in  DATA_WIDTH  MEM stage store data.
- `a_gnt`  out  1  A's access is issued to memory this cycle.
- `a_rvalid`  out  1  `a_rdata` holds A's load result.
- `a_rdata`  out  DATA_WIDTH  load data for A.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same widths and meanings, for port B.
- `mem_addr`  out  ADDR_WIDTH  to `data_mem.addr`.
- `mem_wdata`  out  DATA_WIDTH  to `data_mem.write_data`.
- `mem_we`  out  1  to `data_mem.write_en`.
- `mem_rdata`  in  DATA_WIDTH  from `data_mem.read_data`; valid one cycle after the address is presented.
- `pipe_stall`  out  1  high when `a_req` is high and `a_gnt` is low.

## Operation
- **Grant decision (combinational, same cycle):**
  - Default is fixed priority: A wins over B.
  - `a_gnt = a_req & ~force_b`.
  - `b_gnt = b_req & (~a_req | force_b)`.
  - `force_b` is constant 0 unless `DMEM_ARB_STARVE_EN` is defined.
  - Grants are mutually exclusive.
- **Memory mux:** `mem_addr`, `mem_wdata` and `mem_we` come from the granted port. `mem_we` is that port's `*_we`.
  - With no grant: `mem_addr` = 0, `mem_wdata` = 0, `mem_we` = 0.
- **Read-owner FSM** (registered), states `IDLE`, `RD_A`, `RD_B`:
  - Next state is `RD_A` if A is granted with `a_we` = 0.
  - Next state is `RD_B` if B is granted with `b_we` = 0.
  - Next state is `IDLE` otherwise, covering both writes and no grant.
- **Read return:**
  - `a_rvalid` = (state == `RD_A`); `b_rvalid` = (state == `RD_B`).
  - `a_rdata` = `mem_rdata` when `a_rvalid` is high, else 0. `b_rdata` follows the same rule.
- **Back-to-back accesses** are legal every cycle. A read in cycle N returns in N+1 while a new access is issued in N+1.
- **Stores** complete in the grant cycle. No response strobe is produced.
- **Simultaneous requests:** A wins, B holds its request, and `b_gnt` stays 0. Requesters must hold `*_req` and payload stable until granted.

## Timing
- **Reset values** while `rst` = 0, asynchronous:
  - FSM is `IDLE`; starvation counter is 0.
  - All `*_gnt`, `*_rvalid`, `mem_we`, `pipe_stall` are 0.
  - `*_rdata`, `mem_addr`, `mem_wdata` are 0.
  - Grants are gated by `rst`, so no write can reach memory during reset.
- **Latency:** grant takes 0 cycles (combinational); read data arrives 1 cycle after the grant.
- **Reset during a read:** if reset asserts in the cycle after a read grant, the pending `*_rvalid` is suppressed and never reissued after release.
- **Release:** on the first edge after `rst` rises, the arbiter is fully operational.

## Configuration
- Macro: `DMEM_ARB_STARVE_EN`.
- **Defined:**
  - An 8-bit counter increments each cycle in which `b_req` = 1 and `b_gnt` = 0.
  - The counter clears to 0 on any B grant or when `b_req` = 0.
  - When the counter equals `STARVE_LIMIT`, `force_b` = 1 for that cycle:
    - B is granted even if A requests.
    - A is denied and `pipe_stall` = 1.
    - The counter clears.
- **Undefined:** strict A priority applies, with no counter register and `force_b` tied to 0. B can starve indefinitely.

## Test plan
1. **Reset:** hold `rst` = 0 for 3 cycles with `a_req` = 1, `a_we` = 1 → `mem_we` = 0, all outputs 0, memory contents unchanged.
2. **A store then load:** A stores 0xDEADBEEF to addr 0x10, then loads addr 0x10 → `a_gnt` = 1 both cycles; `a_rvalid` = 1 and `a_rdata` = 0xDEADBEEF one cycle after the load; `b_rvalid` stays 0.
3. **Contention:** `a_req` and `b_req` both high for 1 cycle, B loads addr 0x20 containing 0x12345678 → cycle 0: `a_gnt` = 1, `b_gnt` = 0. Cycle 1 (A idle): `b_gnt` = 1. Cycle 2: `b_rvalid` = 1 with 0x12345678.
4. **Back-to-back reads:** A reads addr 0x4 then B reads addr 0x8 in consecutive cycles → rvalid alternates A then B, each returning its own word.
5. **Starvation** (`DMEM_ARB_STARVE_EN` defined, `STARVE_LIMIT` = 4): A requests continuously, B requests a store → `b_gnt` = 1 exactly once, on the 5th cycle, with `pipe_stall` = 1 that cycle. Without the macro, `b_gnt` stays 0 for 20 cycles.
6. **Reset mid-read:** A load is granted and `rst` is pulsed low the next cycle → `a_rvalid` = 0 and no spurious rvalid after release.
